// File: rtl/jogo_pkg.sv
// Shared definitions for the game input stage: FSM state codes (also shown on the
// debug display) and the default button count.
package jogo_pkg;

  localparam int LARGURA_PAD = 4;

  typedef enum logic [3:0] {
    OCIOSO          = 4'd0,
    CONFIRMA        = 4'd1,
    REGISTRA        = 4'd2,
    ESPERA_SOLTAR   = 4'd3,
    CONFIRMA_SOLTAR = 4'd4
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Button input stage: synchronizes, debounces press and release, latches the stable
// pattern into jogada and emits one tem_jogada pulse per physical press.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int LARGURA         = LARGURA_PAD
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] botoes,
  input  logic               habilita,
  input  logic               limpa,
  output logic [LARGURA-1:0] jogada,
  output logic               tem_jogada,
  output logic [3:0]         db_estado
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [LARGURA-1:0] s;
  logic [LARGURA-1:0] amostra, amostra_n;
  logic [CW-1:0]      cnt, cnt_n;
  estado_t            estado, prox;

  sincronizador_2ff #(.LARGURA(LARGURA)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      cnt     <= '0;
      amostra <= '0;
    end else begin
      estado  <= prox;
      cnt     <= cnt_n;
      amostra <= amostra_n;
    end
  end

  always_comb begin
    prox      = estado;
    cnt_n     = cnt;
    amostra_n = amostra;
    case (estado)
      OCIOSO: begin
        if (s != '0) begin
          if (habilita) begin
            amostra_n = s;
            cnt_n     = '0;
            prox      = CONFIRMA;
          end else begin
            prox = ESPERA_SOLTAR;
          end
        end
      end
      CONFIRMA: begin
        if (!habilita || s == '0) begin
          prox = OCIOSO;
        end else if (s != amostra) begin
          // pattern changed while held: restart debounce on the new value
          amostra_n = s;
          cnt_n     = '0;
        end else if (cnt == CNT_MAX) begin
          prox = REGISTRA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REGISTRA: prox = ESPERA_SOLTAR;
      ESPERA_SOLTAR: begin
        if (s == '0) begin
          cnt_n = '0;
          prox  = CONFIRMA_SOLTAR;
        end
      end
      CONFIRMA_SOLTAR: begin
        if (s != '0)              prox = ESPERA_SOLTAR;
        else if (cnt == CNT_MAX)  prox = OCIOSO;
        else                      cnt_n = cnt + 1'b1;
      end
      default: prox = OCIOSO;
    endcase
  end

  // Loaded on entry to REGISTRA so jogada is already valid while tem_jogada is high;
  // the registration always beats a simultaneous limpa.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                     jogada <= '0;
    else if (prox == REGISTRA || estado == REGISTRA) jogada <= amostra;
    else if (limpa)                                 jogada <= '0;
  end

  assign tem_jogada = (estado == REGISTRA);
  assign db_estado  = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Randomized press/bounce/release episodes checked against a timing model of the
// debounced button interface.
module tb_detector_jogada;
  import jogo_pkg::*;

  localparam int D = 4;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] botoes;
  logic         habilita;
  logic         limpa;
  logic [W-1:0] jogada;
  logic         tem_jogada;
  logic [3:0]   db_estado;

  detector_jogada #(.DEBOUNCE_CICLOS(D), .LARGURA(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .limpa      (limpa),
    .jogada     (jogada),
    .tem_jogada (tem_jogada),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: edge index, start edge of the current constant raw run, expected pulse edge
  int           edge_n     = 0;
  int           run_start  = -1000;
  int           pulse_edge = -1000;
  int           conf_start = -1000;
  bit           hab_ep     = 1'b0;
  logic [W-1:0] prev_b     = '0;
  logic [W-1:0] pulse_val  = '0;
  logic [W-1:0] exp_jog    = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
    end
  endtask

  task automatic drive(input logic [W-1:0] x);
    if (x != prev_b) run_start = edge_n + 1;
    prev_b = x;
    botoes = x;
  endtask

  task automatic tick();
    logic lim;
    lim = limpa;
    @(posedge clock);
    edge_n++;
    if (edge_n == pulse_edge || edge_n == pulse_edge + 1) exp_jog = pulse_val;
    else if (lim) exp_jog = '0;
    #1;
    chk("tem_jogada", tem_jogada, edge_n == pulse_edge);
    chk("jogada", jogada, exp_jog);
    if (hab_ep) begin
      if (edge_n >= conf_start && edge_n < pulse_edge) chk("db_confirma", db_estado, 4'd1);
      else if (edge_n == pulse_edge)                   chk("db_registra", db_estado, 4'd2);
      else if (edge_n == pulse_edge + 1)               chk("db_espera", db_estado, 4'd3);
    end
  endtask

  task automatic arm_pulse(input logic [W-1:0] v);
    hab_ep     = 1'b1;
    pulse_val  = v;
    pulse_edge = run_start + 2 + D;
    conf_start = run_start + 2;
  endtask

  task automatic quiet(input bit rand_ctl);
    for (int i = 0; i < D + 6; i++) begin
      drive('0);
      if (rand_ctl) begin
        habilita = 1'($urandom_range(0, 1));
        limpa    = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    limpa = 1'b0;
    chk("db_ocioso", db_estado, 4'd0);
  endtask

  task automatic episode(input bit hab, input logic [W-1:0] v, input int hold);
    int nb;
    hab_ep     = 1'b0;
    pulse_edge = -1000;
    habilita   = hab;
    nb = $urandom_range(0, D - 1);
    for (int i = 0; i < nb; i++) begin
      drive(W'($urandom_range(0, (1 << W) - 1)));
      limpa = ($urandom_range(0, 7) == 0);
      tick();
    end
    drive(v);
    if (hab) arm_pulse(v);
    for (int i = 0; i < hold; i++) begin
      if (edge_n + 1 <= run_start + 2 + D) habilita = hab;
      else habilita = 1'($urandom_range(0, 1));
      limpa = ($urandom_range(0, 7) == 0);
      tick();
    end
    nb = $urandom_range(0, D - 1);
    for (int i = 0; i < nb; i++) begin
      drive(W'($urandom_range(0, (1 << W) - 1)));
      habilita = 1'($urandom_range(0, 1));
      limpa    = ($urandom_range(0, 7) == 0);
      tick();
    end
    quiet(1'b1);
  endtask

  initial begin
    logic [W-1:0] v;
    reset    = 1'b0;
    habilita = 1'b1;
    limpa    = 1'b0;
    botoes   = 4'b0001;
    prev_b   = 4'b0001;

    // reset held with a button pressed
    repeat (3) @(posedge clock);
    #1;
    chk("rst_jogada", jogada, '0);
    chk("rst_tem", tem_jogada, 1'b0);
    chk("rst_db", db_estado, 4'd0);

    // release reset, get into CONFIRMA, then reset again mid-debounce
    reset     = 1'b1;
    run_start = edge_n + 1;
    arm_pulse(4'b0001);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_db", db_estado, 4'd0);
    chk("rst_mid_tem", tem_jogada, 1'b0);
    chk("rst_mid_jogada", jogada, '0);
    exp_jog    = '0;
    pulse_edge = -1000;
    #1;

    // still-held button goes through a full debounce after reset
    reset     = 1'b1;
    run_start = edge_n + 1;
    arm_pulse(4'b0001);
    while (edge_n < pulse_edge + 3) tick();
    quiet(1'b0);

    // limpa clears jogada without disturbing the FSM
    chk("pre_limpa", jogada, 4'b0001);
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    chk("limpa_db", db_estado, 4'd0);
    chk("limpa_jogada", jogada, '0);

    // directed: pattern with multiple bits, long hold, then a second press
    episode(1'b1, 4'b1010, 100);
    episode(1'b1, 4'b0100, D + 6);
    episode(1'b0, 4'b0001, D + 8);

    for (int ep = 0; ep < 40; ep++) begin
      v = W'($urandom_range(1, (1 << W) - 1));
      episode($urandom_range(0, 3) != 0, v, $urandom_range(D + 4, D + 20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
